// File: rtl/cmd_interp.sv
// cmd_interp: ASCII infix parser turning "<A><op><B>=" strobes into ALU operands, opcode and a rdy pulse.
module cmd_interp (
    input  logic       clk,
    input  logic       rst,
    input  logic       strt,
    input  logic [7:0] data,
    output logic [7:0] op_A,
    output logic [7:0] op_B,
    output logic [3:0] cmd,
    output logic [7:0] debug,
    output logic       rdy
);
    typedef enum logic [1:0] {GET_A, GET_B, DONE} state_t;
    state_t     state, state_n;
    logic       b_flag, b_flag_n, rdy_n;
    logic [7:0] a_n, b_n;
    logic [3:0] cmd_n, code;
    logic       is_digit, is_op, is_eq, is_clr;
    always_comb begin
        case (data)
            8'h2B:   code = 4'd1;
            8'h2D:   code = 4'd2;
            8'h2A:   code = 4'd3;
            8'h2F:   code = 4'd4;
            8'h25:   code = 4'd5;
            8'h26:   code = 4'd6;
            8'h7C:   code = 4'd7;
            8'h5E:   code = 4'd8;
            8'h3C:   code = 4'd9;
            8'h3E:   code = 4'd10;
            default: code = 4'd0;
        endcase
    end
    assign is_digit = data >= 8'h30 && data <= 8'h39;
    assign is_op    = code != 4'd0;
    assign is_eq    = data == 8'h3D;
    assign is_clr   = data == 8'h21;
    always_comb begin
        state_n  = state;
        a_n      = op_A;
        b_n      = op_B;
        cmd_n    = cmd;
        b_flag_n = b_flag;
        rdy_n    = 1'b0;
        if (strt) begin
            if (is_clr) begin
                a_n     = 8'd0;
                b_n     = 8'd0;
                cmd_n   = 4'd0;
                state_n = GET_A;
            end else begin
                case (state)
                    GET_A: begin
                        if (is_digit)
                            a_n = 8'(({4'd0, op_A} * 12'd10) + {8'd0, data[3:0]});
                        else if (is_op) begin
                            cmd_n    = code;
                            b_n      = 8'd0;
                            b_flag_n = 1'b0;
                            state_n  = GET_B;
                        end
                    end
                    GET_B: begin
                        if (is_digit) begin
                            b_n      = 8'(({4'd0, op_B} * 12'd10) + {8'd0, data[3:0]});
                            b_flag_n = 1'b1;
                        end else if (is_op && !b_flag)
                            cmd_n = code;
                        else if (is_eq) begin
                            rdy_n   = 1'b1;
                            state_n = DONE;
                        end
                    end
                    DONE: begin
                        if (is_digit) begin
                            a_n     = {4'd0, data[3:0]};
                            b_n     = 8'd0;
                            cmd_n   = 4'd0;
                            state_n = GET_A;
                        end else if (is_op) begin
                            cmd_n    = code;
                            b_n      = 8'd0;
                            b_flag_n = 1'b0;
                            state_n  = GET_B;
                        end
                    end
                    default: state_n = GET_A;
                endcase
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= GET_A;
            b_flag <= 1'b0;
            op_A   <= 8'd0;
            op_B   <= 8'd0;
            cmd    <= 4'd0;
            debug  <= 8'd0;
            rdy    <= 1'b0;
        end else begin
            state  <= state_n;
            b_flag <= b_flag_n;
            op_A   <= a_n;
            op_B   <= b_n;
            cmd    <= cmd_n;
            rdy    <= rdy_n;
            if (strt) debug <= data;
        end
    end
endmodule

// File: tb/tb_cmd_interp.sv
// tb_cmd_interp: directed vector table plus hand sequences for held strobes and mid-expression reset.
module tb_cmd_interp;
    logic       clk = 1'b0, rst = 1'b1, strt = 1'b0;
    logic [7:0] data = 8'd0;
    logic [7:0] op_A, op_B, debug;
    logic [3:0] cmd;
    logic       rdy;
    int         n_vec = 0, n_bad = 0, rdy_cnt = 0;
    typedef struct {
        logic [7:0] ch, a, b;
        logic [3:0] c;
        logic       r;
    } vec_t;
    vec_t tbl[$];
    cmd_interp dut (
        .clk(clk), .rst(rst), .strt(strt), .data(data),
        .op_A(op_A), .op_B(op_B), .cmd(cmd), .debug(debug), .rdy(rdy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) rdy_cnt <= rdy_cnt + int'(rdy);
    function automatic logic [28:0] outs();
        return {rdy, cmd, debug, op_B, op_A};
    endfunction
    task automatic chk(input string nm, input logic [28:0] act, input logic [28:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got rdy=%0b cmd=%0d debug=%h B=%h A=%h, want rdy=%0b cmd=%0d debug=%h B=%h A=%h",
                     nm, act[28], act[27:24], act[23:16], act[15:8], act[7:0],
                     exp[28], exp[27:24], exp[23:16], exp[15:8], exp[7:0]);
        end
    endtask
    task automatic add(input logic [7:0] ch, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] c, input logic r);
        vec_t v;
        v.ch = ch; v.a = a; v.b = b; v.c = c; v.r = r;
        tbl.push_back(v);
    endtask
    task automatic send(input logic [7:0] ch);
        @(negedge clk);
        strt = 1'b1;
        data = ch;
        @(negedge clk);
        strt = 1'b0;
    endtask
    initial begin
        int exp_rdy, base;
        add("2", 8'd2,   8'd0,  4'd0,  1'b0);
        add("+", 8'd2,   8'd0,  4'd1,  1'b0);
        add("1", 8'd2,   8'd1,  4'd1,  1'b0);
        add("5", 8'd2,   8'd15, 4'd1,  1'b0);
        add("=", 8'd2,   8'd15, 4'd1,  1'b1);
        add("!", 8'd0,   8'd0,  4'd0,  1'b0);
        add("3", 8'd3,   8'd0,  4'd0,  1'b0);
        add("0", 8'd30,  8'd0,  4'd0,  1'b0);
        add("0", 8'h2C,  8'd0,  4'd0,  1'b0);
        add("*", 8'h2C,  8'd0,  4'd3,  1'b0);
        add("2", 8'h2C,  8'd2,  4'd3,  1'b0);
        add("=", 8'h2C,  8'd2,  4'd3,  1'b1);
        add("=", 8'h2C,  8'd2,  4'd3,  1'b0);
        add("9", 8'd9,   8'd0,  4'd0,  1'b0);
        add("x", 8'd9,   8'd0,  4'd0,  1'b0);
        add("-", 8'd9,   8'd0,  4'd2,  1'b0);
        add("+", 8'd9,   8'd0,  4'd1,  1'b0);
        add("7", 8'd9,   8'd7,  4'd1,  1'b0);
        add("-", 8'd9,   8'd7,  4'd1,  1'b0);
        add("=", 8'd9,   8'd7,  4'd1,  1'b1);
        add("=", 8'd9,   8'd7,  4'd1,  1'b0);
        add("&", 8'd9,   8'd0,  4'd6,  1'b0);
        add("3", 8'd9,   8'd3,  4'd6,  1'b0);
        add("=", 8'd9,   8'd3,  4'd6,  1'b1);
        add("4", 8'd4,   8'd0,  4'd0,  1'b0);
        add("=", 8'd4,   8'd0,  4'd0,  1'b0);
        add("9", 8'd49,  8'd0,  4'd0,  1'b0);
        add("9", 8'd243, 8'd0,  4'd0,  1'b0);
        add("9", 8'd135, 8'd0,  4'd0,  1'b0);
        add("<", 8'd135, 8'd0,  4'd9,  1'b0);
        add(">", 8'd135, 8'd0,  4'd10, 1'b0);
        add("=", 8'd135, 8'd0,  4'd10, 1'b1);
        repeat (10) @(negedge clk);
        chk("reset_held", outs(), 29'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_release", outs(), 29'd0);
        exp_rdy = 0;
        base = rdy_cnt;
        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].ch);
            chk($sformatf("vec%0d_%s", i, string'(tbl[i].ch)), outs(),
                {tbl[i].r, tbl[i].c, tbl[i].ch, tbl[i].b, tbl[i].a});
            @(negedge clk);
            chk($sformatf("vec%0d_hold", i), outs(),
                {1'b0, tbl[i].c, tbl[i].ch, tbl[i].b, tbl[i].a});
            if (tbl[i].r) exp_rdy++;
        end
        repeat (2) @(negedge clk);
        chk("rdy_pulse_count", 29'(rdy_cnt - base), 29'(exp_rdy));
        @(negedge clk);
        strt = 1'b1;
        data = "!";
        @(negedge clk);
        data = "5";
        repeat (2) @(negedge clk);
        strt = 1'b0;
        chk("held_strobe", outs(), {1'b0, 4'd0, 8'h35, 8'd0, 8'd55});
        send("+");
        chk("pre_reset_op", outs(), {1'b0, 4'd1, 8'h2B, 8'd0, 8'd55});
        @(negedge clk);
        strt = 1'b1;
        data = "=";
        @(posedge clk);
        #1;
        rst = 1'b1;
        strt = 1'b0;
        #1;
        chk("async_reset_cancels_rdy", outs(), 29'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("after_mid_reset", outs(), 29'd0);
        send("7");
        chk("restart_get_a", outs(), {1'b0, 4'd0, 8'h37, 8'd0, 8'd7});
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/cmd_interp.md
Name:
cmd_interp

Overview:
- ASCII command interpreter for the calculator datapath.
- Consumes one character per `strt` strobe, typically from the UART receiver.
- Parses infix expressions of the form `<decimal A><operator><decimal B>=`.
- Presents the parsed operands and an operation code to the ALU, with a one-cycle `rdy` pulse when the expression is complete.

Parameters:
- None.

Ports:
- `clk`    in   1  system clock; all state changes on the rising edge.
- `rst`    in   1  reset; asynchronous, active-high.
- `strt`   in   1  character strobe; `data` is valid in any cycle where `strt`=1.
- `data`   in   8  ASCII character.
- `op_A`   out  8  operand A, unsigned binary.
- `op_B`   out  8  operand B, unsigned binary.
- `cmd`    out  4  operation code; encoding under Behaviour.
- `debug`  out  8  last character accepted on a `strt` cycle.
- `rdy`    out  1  one-cycle pulse: `op_A`/`op_B`/`cmd` form a complete expression.

Behaviour:
- Reset (asynchronous, `rst`=1):
  - `op_A`=0, `op_B`=0, `cmd`=0, `debug`=0, `rdy`=0.
  - State = `GET_A`, B-digit flag cleared.
- All outputs are registered.
- A character is processed only on a rising edge with `strt`=1. No other input is sampled.
- `strt` held high for N cycles processes the same character N times; the source must deliver one-cycle strobes.
- `debug` loads `data` on every `strt` edge, whatever the character class.
- `rdy` defaults to 0 every cycle. It is 1 only for the cycle after the edge that accepted a valid `=`.
- Character classes:
  - digit: 0x30-0x39.
  - operator, with `cmd` code:
    - `+` → 1, `-` → 2, `*` → 3, `/` → 4, `%` → 5
    - `&` → 6, `|` → 7, `^` → 8, `<` → 9 (shift left), `>` → 10 (shift right)
  - `=` (0x3D): execute.
  - `!` (0x21): clear.
  - anything else: ignored; only `debug` updates.
- Digit accumulation:
  - operand ← operand*10 + (`data` − 0x30), truncated to 8 bits (mod 256).
  - Computed in at least 12-bit intermediate width, then truncated.
- States:
  - `GET_A`:
    - digit → accumulate into `op_A`.
    - operator → `cmd`=code, `op_B`=0, clear B-digit flag, go to `GET_B`. `op_A` may still be 0 if no digits were entered.
    - `=` → ignored.
  - `GET_B`:
    - digit → accumulate into `op_B`, set B-digit flag.
    - operator → replaces `cmd` if B-digit flag is 0; ignored otherwise.
    - `=` → `rdy`=1 for one cycle, go to `DONE`. Allowed with no B digits, giving `op_B`=0.
  - `DONE`:
    - `op_A`/`op_B`/`cmd` held stable.
    - digit → new expression: `op_A`=digit value, `op_B`=0, `cmd`=0, go to `GET_A`.
    - operator → chain on the previous A: `cmd`=code, `op_B`=0, clear B-digit flag, go to `GET_B`.
    - `=` → ignored; no second `rdy`.
  - `!` in any state → `op_A`=0, `op_B`=0, `cmd`=0, go to `GET_A`, no `rdy`.
- Reset mid-expression:
  - Immediate clear to reset values.
  - A `rdy` pulse in flight is cancelled.
- Implementation requirements:
  - 2-bit state register.
  - 1-bit B-digit flag.
  - Fully registered; no combinational path from `data` to outputs.

Test Plan:
- Reset (`rst`=1 for 100 ns), then release → all outputs 0, state `GET_A`.
- Strobes "2", "+", "1", "5", "=" (10 ns `strt` pulses, 100 ns apart):
  - after "2": `op_A`=0x02.
  - after "+": `cmd`=1, `op_B`=0.
  - after "1": `op_B`=0x01; after "5": `op_B`=0x0F.
  - "=" → `rdy` high exactly one clock; values stable after.
  - `debug` tracks 0x32, 0x2B, 0x31, 0x35, 0x3D.
- Following "!" (0x21) → `op_A`=0, `op_B`=0, `cmd`=0, `rdy` stays 0, `debug`=0x21.
- Overflow: "3","0","0","*","2","=" → `op_A`=0x2C (300 mod 256), `cmd`=3, `op_B`=2, one `rdy` pulse.
- Robustness sequence "9","x","-","+","7","=","=":
  - "x" is ignored; `debug` shows 0x78.
  - `cmd` ends 1 (the "+" replaces "-").
  - `op_A`=9, `op_B`=7, exactly one `rdy` pulse.
- Chaining / new expression:
  - after `DONE`, "&","3","=" → `cmd`=6, `op_A` unchanged, `op_B`=3, `rdy` pulse.
  - then "4" → `op_A`=4, `op_B`=0, `cmd`=0.
  - assert `rst` mid-entry → all outputs clear immediately.
